// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, even parity, one stop bit.
// A small FIFO buffers bytes, and the bit period can be changed at run time.
module uart_tx #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 50000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_bit_period_i,
    input  logic [15:0]                   bit_period_i,
    input  logic                          uart_tx_en,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BP_RESET = 16'((CLK_FREQ / BAUD_RATE) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // ---------------- FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          full, empty, push, pop;

    assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = tx_valid_i && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end

    // ---------------- Transmit FSM ----------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bp_q, bp_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        parity_q, parity_d;
    logic        txd_q, txd_d;
    logic [7:0]  head;

    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bp_q      <= BP_RESET;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bp_q      <= bp_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - 16'd1 : cnt_q;
        bp_d      = bp_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        if (wr_bit_period_i) begin
            // A new rate makes the in-flight frame meaningless, so it is dropped.
            bp_d    = bit_period_i;
            state_d = S_IDLE;
            txd_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_d = 1'b1;
                    if (uart_tx_en && !empty) begin
                        pop      = 1'b1;
                        shift_d  = head;
                        parity_d = ^head;
                        cnt_d    = bp_q;
                        txd_d    = 1'b0;
                        state_d  = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        txd_d     = shift_q[0];
                        bit_idx_d = '0;
                        cnt_d     = bp_q;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_d = shift_q >> 1;
                        cnt_d   = bp_q;
                        if (bit_idx_q < 3'd7) begin
                            txd_d     = shift_q[1];
                            bit_idx_d = bit_idx_q + 3'd1;
                        end else begin
                            txd_d   = parity_q;
                            state_d = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        txd_d   = 1'b1;
                        cnt_d   = bp_q;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        cnt_d = bp_q;
                        // Chain straight into the next frame with no idle gap.
                        if (uart_tx_en && !empty) begin
                            pop      = 1'b1;
                            shift_d  = head;
                            parity_d = ^head;
                            txd_d    = 1'b0;
                            state_d  = S_START;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign uart_txd      = txd_q;
    assign uart_tx_busy  = (state_q != S_IDLE);
    assign tx_ready_o    = !full;
    assign tx_fifo_level = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_uart_tx;

    localparam int DEPTH  = 4;
    localparam int BP_DEF = 50000000 / 115200 - 1;

    logic        clk = 1'b0;
    logic        rst, wr_bp, en, valid;
    logic [15:0] bp_in;
    logic [7:0]  data;
    logic        ready, txd, busy;
    logic [2:0]  level;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_RATE(115200), .CLK_FREQ(50000000), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_bit_period_i (wr_bp),
        .bit_period_i    (bp_in),
        .uart_tx_en      (en),
        .tx_data_i       (data),
        .tx_valid_i      (valid),
        .tx_ready_o      (ready),
        .uart_txd        (txd),
        .uart_tx_busy    (busy),
        .tx_fifo_level   (level)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queued bytes, the 11-bit frame being sent, and the
    // position/time left within it.
    byte unsigned mq[$];
    logic         fr[11];
    int           pos   = -1;
    int           left  = 0;
    int           mbp   = BP_DEF;
    logic         m_txd = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input byte unsigned b);
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = b[i];
        fr[9]  = ^b;
        fr[10] = 1'b1;
        pos    = 0;
        left   = mbp;
        m_txd  = 1'b0;
    endtask

    task automatic model_edge();
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (rst) begin
            mq.delete();
            pos   = -1;
            left  = 0;
            mbp   = BP_DEF;
            m_txd = 1'b1;
        end else begin
            if (wr_bp) begin
                pos   = -1;
                m_txd = 1'b1;
                mbp   = int'(bp_in);
            end else if (pos < 0) begin
                if (en && mq.size() > 0) start_frame(mq.pop_front());
            end else if (left > 0) begin
                left--;
            end else begin
                pos++;
                if (pos == 11) begin
                    if (en && mq.size() > 0) start_frame(mq.pop_front());
                    else begin
                        pos   = -1;
                        m_txd = 1'b1;
                    end
                end else begin
                    m_txd = fr[pos];
                    left  = mbp;
                end
            end
            if (valid && !was_full) mq.push_back(data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("txd",   txd,   m_txd);
        chk("busy",  busy,  pos >= 0);
        chk("level", level, mq.size());
        chk("ready", ready, mq.size() < DEPTH);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input byte unsigned b);
        valid = 1'b1;
        data  = b;
        tick();
        valid = 1'b0;
    endtask

    task automatic set_bp(input int v);
        wr_bp = 1'b1;
        bp_in = 16'(v);
        tick();
        wr_bp = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((pos >= 0 || (en && mq.size() > 0)) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_vec++;
            n_err++;
            $error("FAIL wait_idle: observed timeout after %0d cycles expected idle", k);
        end
    endtask

    // Counts consecutive busy cycles following the current point.
    task automatic busy_run(input int budget, output int c);
        c = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) break;
            c++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        logic [10:0] seen, e;
        rst = 1'b1; wr_bp = 1'b0; bp_in = '0; en = 1'b1; valid = 1'b0; data = '0;
        run(2);
        rst = 1'b0;
        tick();
        chk("rst_txd",   txd,   1);
        chk("rst_busy",  busy,  0);
        chk("rst_level", level, 0);
        chk("rst_ready", ready, 1);

        // Reset-time bit period: 433 -> 434 cycles per bit.
        push(8'h3C);
        busy_run(6000, c);
        chk("default_frame_cycles", c, 11 * (BP_DEF + 1));
        wait_idle(100);

        // 0xA5 at 10 cycles per bit.
        set_bp(9);
        push(8'hA5);
        c = 0; seen = '0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (busy) c++;
            if ((i - 1) % 10 == 5 && (i - 1) / 10 < 11) seen[(i-1)/10] = txd;
        end
        e = {1'b1, 1'b0, 8'hA5, 1'b0};
        chk("a5_busy_cycles", c, 110);
        for (int b = 0; b < 11; b++) chk($sformatf("a5_bit%0d", b), seen[b], e[b]);

        // Parity of 0x07 is 1; 0x00 holds the line low for 10 bits.
        push(8'h07);
        for (int i = 1; i <= 115; i++) begin
            tick();
            if (i == 96) seen[9] = txd;
        end
        chk("p07_parity", seen[9], 1);
        push(8'h00);
        c = 0;
        for (int i = 1; i <= 115; i++) begin
            tick();
            if (txd == 1'b0) c++;
        end
        chk("z00_low_cycles", c, 100);

        // FIFO full: 5 writes with en low, 4 accepted; then 4 gapless frames.
        en = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = 8'($urandom);
            tick();
        end
        valid = 1'b0;
        chk("full_level", level, 4);
        chk("full_ready", ready, 0);
        en = 1'b1;
        busy_run(500, c);
        chk("b2b_cycles", c, 440);
        chk("b2b_level", level, 0);

        // Bit-period write during the 3rd data bit aborts the frame.
        push(8'($urandom));
        push(8'($urandom));
        run(33);
        set_bp(4);
        chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        busy_run(100, c);
        chk("after_abort_cycles", c, 55);
        wait_idle(100);

        // Reset mid-frame with 2 bytes queued.
        en = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        en = 1'b1;
        run(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_txd",   txd,   1);
        chk("midrst_level", level, 0);
        chk("midrst_ready", ready, 1);
        run(3);

        // One cycle per bit.
        set_bp(0);
        push(8'h5A);
        busy_run(50, c);
        chk("bp0_cycles", c, 11);
        push(8'($urandom)); push(8'($urandom));
        wait_idle(100);

        // en dropped mid-frame: current frame completes, next stays queued.
        set_bp(2);
        push(8'hC3); push(8'h96);
        run(5);
        en = 1'b0;
        busy_run(100, c);
        chk("en_off_level", level, 1);
        run(10);
        chk("en_off_busy", busy, 0);
        en = 1'b1;
        tick();
        chk("en_on_busy", busy, 1);
        wait_idle(100);

        // Random traffic.
        set_bp(1);
        for (int i = 0; i < 2000; i++) begin
            valid = ($urandom % 100) < 30;
            data  = 8'($urandom);
            en    = ($urandom % 40) != 0;
            wr_bp = ($urandom % 300) == 0;
            bp_in = 16'($urandom_range(0, 3));
            rst   = ($urandom % 1000) == 0;
            tick();
        end
        valid = 1'b0; wr_bp = 1'b0; rst = 1'b0; en = 1'b1;
        wait_idle(3000);
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
